// File: rtl/store_pkg.sv
// Shared types for the store FIFO: size encodings, the pre-aligned queue entry
// and the drain state machine encoding.
package store_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [29:0] addr_w;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Converts a right-aligned store (addr, size, value) into a word address,
// lane-replicated write data and byte strobes.
module store_lane_align
  import store_pkg::*;
(
  input  logic [31:0]  addr,
  input  logic [1:0]   size,
  input  logic [31:0]  val,
  output store_entry_t entry
);

  // Size 3 falls through to the word case along with SIZE_WORD.
  always_comb begin
    entry.addr_w = addr[31:2];
    entry.wdata  = val;
    entry.wstrb  = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        entry.wdata = {4{val[7:0]}};
        entry.wstrb = 4'b0001 << addr[1:0];
      end
      SIZE_HALF: begin
        entry.wdata = {2{val[15:0]}};
        entry.wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        entry.wdata = val;
        entry.wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/store_fifo.sv
// Queues committed stores and drains them one at a time to the data-memory
// write port; flags loads that hit a word still waiting to be written.
module store_fifo
  import store_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_val,
  input  logic [1:0]  store_size,
  input  logic        store_valid,
  output logic        storefifo_full,
  output logic        storefifo_empty,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] load_check_addr,
  output logic        load_conflict,
  output logic        overflow
);

  store_entry_t            entries [DEPTH];
  store_entry_t            push_entry;
  logic [PTR_W-1:0]        wptr;
  logic [PTR_W-1:0]        rptr;
  logic [PTR_W:0]          count;
  logic [PTR_W:0]          count_next;
  drain_state_t            state;
  drain_state_t            state_next;
  logic                    push;
  logic                    pop;
  logic [DEPTH-1:0]        slot_hit;
  logic                    unused_load_lsb;

  store_lane_align u_align (
    .addr  (store_addr),
    .size  (store_size),
    .val   (store_val),
    .entry (push_entry)
  );

  assign storefifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign storefifo_empty = (count == '0) && (state == IDLE);
  assign push            = store_valid && !storefifo_full;
  assign unused_load_lsb = ^load_check_addr[1:0];

  // Drain state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Drain next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack && (count == '0)) begin
          state_next = IDLE;
        end else begin
          state_next = BUSY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drain outputs: when the head is moved into the memory-port registers
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count != '0);
      BUSY:    pop = mem_ack && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  // Occupancy: a same-cycle push and pop leave the count unchanged
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (store_valid && storefifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Queue storage holds data only; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wptr] <= push_entry;
    end
  end

  // Memory-port registers stay stable for the whole of a request
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
    end else begin
      mem_req <= (state_next == BUSY);
      if (pop) begin
        mem_addr  <= {entries[rptr].addr_w, 2'b00};
        mem_wdata <= entries[rptr].wdata;
        mem_wstrb <= entries[rptr].wstrb;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] off;
    assign off         = PTR_W'(g) - rptr;
    assign slot_hit[g] = ({1'b0, off} < count) &&
                         (entries[g].addr_w == load_check_addr[31:2]);
  end

  assign load_conflict = (|slot_hit) ||
                         ((state == BUSY) && (mem_addr[31:2] == load_check_addr[31:2]));

endmodule

// File: tb/tb_store_fifo.sv
// Self-checking bench for store_fifo: alignment vectors, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_store_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] store_addr;
  logic [31:0] store_val;
  logic [1:0]  store_size;
  logic        store_valid;
  logic        storefifo_full;
  logic        storefifo_empty;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] load_check_addr;
  logic        load_conflict;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  store_fifo #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .store_addr      (store_addr),
    .store_val       (store_val),
    .store_size      (store_size),
    .store_valid     (store_valid),
    .storefifo_full  (storefifo_full),
    .storefifo_empty (storefifo_empty),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .load_check_addr (load_check_addr),
    .load_conflict   (load_conflict),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] val;
    logic [1:0]  size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ref_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversion written with plain arithmetic.
  function automatic ref_t conv(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    ref_t r;
    r.addr = a & 32'hFFFF_FFFC;
    if (s == 2'd0) begin
      r.wdata = {24'd0, v[7:0]} * 32'h0101_0101;
      r.wstrb = 4'd1 << a[1:0];
    end else if (s == 2'd1) begin
      r.wdata = {16'd0, v[15:0]} * 32'h0001_0001;
      r.wstrb = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      r.wdata = v;
      r.wstrb = 4'b1111;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
    store_valid = 1'b1;
    store_addr  = a;
    store_val   = v;
    store_size  = s;
  endtask

  vec_t vecs [6];
  ref_t pend [$];
  bit   inflight;
  bit   model_ovf;
  bit   exp_conf;
  bit   accepted;
  int   queued;

  initial begin
    vecs[0] = '{32'h0000_1003, 32'h0000_00AB, 2'd0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
    vecs[1] = '{32'h0000_2002, 32'h0000_1234, 2'd1, 32'h0000_2000, 32'h1234_1234, 4'b1100};
    vecs[2] = '{32'h0000_3000, 32'hDEAD_BEEF, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111};
    vecs[3] = '{32'h0000_6001, 32'h1234_56CD, 2'd0, 32'h0000_6000, 32'hCDCD_CDCD, 4'b0010};
    vecs[4] = '{32'h0000_5001, 32'hFFFF_5678, 2'd1, 32'h0000_5000, 32'h5678_5678, 4'b0011};
    vecs[5] = '{32'h0000_7003, 32'h0102_0304, 2'd3, 32'h0000_7000, 32'h0102_0304, 4'b1111};

    reset = 1'b1; store_valid = 1'b0; store_addr = 32'h0; store_val = 32'h0;
    store_size = 2'd0; mem_ack = 1'b0; load_check_addr = 32'h0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_empty", 32'(storefifo_empty), 32'd1);
    chk("rst_full",  32'(storefifo_full), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'h0);

    // Alignment vectors with ack held high
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_store(vecs[i].addr, vecs[i].val, vecs[i].size);
      tick();
      store_valid = 1'b0;
      #1;
      chk("vec_req_n1", 32'(mem_req), 32'd0);
      tick();
      chk("vec_req_n2", 32'(mem_req), 32'd1);
      chk("vec_addr",   mem_addr, vecs[i].e_addr);
      chk("vec_wdata",  mem_wdata, vecs[i].e_wdata);
      chk("vec_wstrb",  32'(mem_wstrb), 32'(vecs[i].e_wstrb));
      tick();
      chk("vec_req_off", 32'(mem_req), 32'd0);
      chk("vec_empty",   32'(storefifo_empty), 32'd1);
    end

    // Fill to capacity with ack stalled, then overflow
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_store(32'h0000_8000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2);
      tick();
    end
    store_valid = 1'b0;
    #1;
    chk("fill_full", 32'(storefifo_full), 32'd1);
    chk("fill_ovf",  32'(overflow), 32'd0);
    drive_store(32'h0000_9000, 32'h5555_5555, 2'd2);
    tick();
    store_valid = 1'b0;
    #1;
    chk("ovf_set",  32'(overflow), 32'd1);
    chk("ovf_full", 32'(storefifo_full), 32'd1);
    mem_ack = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_req",   32'(mem_req), 32'd1);
      chk("drain_wdata", mem_wdata, 32'hA000_0000 + 32'(i));
      tick();
    end
    chk("drain_req_off", 32'(mem_req), 32'd0);
    chk("drain_empty",   32'(storefifo_empty), 32'd1);
    chk("ovf_sticky",    32'(overflow), 32'd1);

    // Load conflict against in-flight and queued entries
    mem_ack = 1'b0;
    drive_store(32'h0000_4000, 32'h0000_0001, 2'd2);
    tick();
    drive_store(32'h0000_4010, 32'h0000_0002, 2'd2);
    tick();
    store_valid = 1'b0;
    load_check_addr = 32'h0000_4002; #1;
    chk("conf_inflight", 32'(load_conflict), 32'd1);
    load_check_addr = 32'h0000_4004; #1;
    chk("conf_next_word", 32'(load_conflict), 32'd0);
    load_check_addr = 32'h0000_4012; #1;
    chk("conf_queued", 32'(load_conflict), 32'd1);
    load_check_addr = 32'h0000_4020; #1;
    chk("conf_miss", 32'(load_conflict), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    load_check_addr = 32'h0000_4002; #1;
    chk("conf_after_ack", 32'(load_conflict), 32'd0);
    load_check_addr = 32'h0000_4010; #1;
    chk("conf_second", 32'(load_conflict), 32'd1);
    mem_ack = 1'b1;
    for (int i = 0; i < 20 && !storefifo_empty; i++) begin
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("conf_drained", 32'(storefifo_empty), 32'd1);
    chk("conf_clear",   32'(load_conflict), 32'd0);

    // Reset while busy with three queued
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h0000_C000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 2'd2);
      tick();
    end
    store_valid = 1'b0;
    #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_req",   32'(mem_req), 32'd0);
    chk("mid_rst_empty", 32'(storefifo_empty), 32'd1);
    chk("mid_rst_ovf",   32'(overflow), 32'd0);
    chk("mid_rst_full",  32'(storefifo_full), 32'd0);
    chk("mid_rst_addr",  mem_addr, 32'h0);
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_stale_req", 32'(mem_req), 32'd0);
    end

    // Randomized traffic against the reference model
    inflight  = 1'b0;
    model_ovf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      store_valid     = ($urandom_range(0, 99) < 55);
      store_addr      = 32'h0000_0100 + 32'($urandom_range(0, 63));
      store_val       = $urandom;
      store_size      = 2'($urandom_range(0, 3));
      mem_ack         = ($urandom_range(0, 99) < 45);
      load_check_addr = 32'h0000_0100 + 32'($urandom_range(0, 79));
      #1;
      queued = pend.size() - (inflight ? 1 : 0);
      exp_conf = 1'b0;
      foreach (pend[k]) begin
        if (pend[k].addr[31:2] == load_check_addr[31:2]) exp_conf = 1'b1;
      end
      chk("rnd_full",  32'(storefifo_full), 32'(queued == DEPTH));
      chk("rnd_empty", 32'(storefifo_empty), 32'(pend.size() == 0));
      chk("rnd_req",   32'(mem_req), 32'(inflight));
      chk("rnd_ovf",   32'(overflow), 32'(model_ovf));
      chk("rnd_conf",  32'(load_conflict), 32'(exp_conf));
      if (inflight) begin
        chk("rnd_addr",  mem_addr, pend[0].addr);
        chk("rnd_wdata", mem_wdata, pend[0].wdata);
        chk("rnd_wstrb", 32'(mem_wstrb), 32'(pend[0].wstrb));
      end
      accepted = store_valid && (queued != DEPTH);
      if (store_valid && (queued == DEPTH)) model_ovf = 1'b1;
      if (inflight && mem_ack) begin
        pend.delete(0);
        inflight = (queued > 0);
      end else if (!inflight) begin
        inflight = (queued > 0);
      end
      if (accepted) pend.push_back(conv(store_addr, store_val, store_size));
      tick();
    end
    store_valid = 1'b0;
    mem_ack     = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
